// File: rtl/fifo_wr_ptr_full.sv
`default_nettype none
// ============================================================================
// Module      : fifo_wr_ptr_full
// Description : Write-side pointer and flag stage of a dual-clock FIFO. It
//               keeps the binary write pointer, drives the RAM write address,
//               publishes a registered Gray write pointer for the read-domain
//               synchronizer and produces the full / wr_ack / overflow flags
//               from the Gray read pointer already synchronized to clk.
//               Optional feature macro FIFO_ALMOST_FULL_EN adds a registered
//               almost_full output driven by a free-slot comparison.
// Revision    : 1.0 - initial release
// ============================================================================
module fifo_wr_ptr_full #(
    parameter int ADDR_RANGE    = 3,
    parameter int ALMOST_MARGIN = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_en,
    input  logic [ADDR_RANGE:0]   rd_ptr_sync,
    output logic [ADDR_RANGE-1:0] wr_addr,
    output logic [ADDR_RANGE:0]   wr_ptr_gray,
    output logic                  wr_ram_en,
    output logic                  full,
    output logic                  wr_ack,
    output logic                  overflow
`ifdef FIFO_ALMOST_FULL_EN
    ,
    output logic                  almost_full
`endif
);

    // Pointers carry one extra wrap bit above the RAM address.
    localparam int C_PW = ADDR_RANGE + 1;

    // Reject illegal configurations at elaboration time.
    generate
        if (ADDR_RANGE < 2 || ALMOST_MARGIN < 0) begin : g_param_check
            $error("fifo_wr_ptr_full: ADDR_RANGE must be >= 2 and ALMOST_MARGIN >= 0");
        end
    endgenerate

    logic [C_PW-1:0] r_wr_bin;
    logic [C_PW-1:0] r_wr_gray;
    logic            r_full;
    logic            r_wr_ack;
    logic            r_overflow;

    logic            w_accept;
    logic [C_PW-1:0] w_wr_bin_nxt;
    logic [C_PW-1:0] w_wr_gray_nxt;
    logic [C_PW-1:0] w_full_match;

    // A write is taken only when the FIFO is not (pessimistically) full.
    assign w_accept      = wr_en & ~r_full;
    assign w_wr_bin_nxt  = r_wr_bin + {{ADDR_RANGE{1'b0}}, w_accept};
    assign w_wr_gray_nxt = w_wr_bin_nxt ^ (w_wr_bin_nxt >> 1);

    // In Gray code, "one full lap ahead" means the top two bits are inverted
    // and the rest are equal.
    assign w_full_match  = {~rd_ptr_sync[ADDR_RANGE:ADDR_RANGE-1],
                            rd_ptr_sync[ADDR_RANGE-2:0]};

    assign wr_ram_en   = w_accept;
    assign wr_addr     = r_wr_bin[ADDR_RANGE-1:0];
    assign wr_ptr_gray = r_wr_gray;
    assign full        = r_full;
    assign wr_ack      = r_wr_ack;
    assign overflow    = r_overflow;

    // Pointer and flag registers; full is re-evaluated every cycle so a read
    // pointer advance clears it even when no write is requested.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_bin   <= '0;
            r_wr_gray  <= '0;
            r_full     <= 1'b0;
            r_wr_ack   <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            r_wr_bin   <= w_wr_bin_nxt;
            r_wr_gray  <= w_wr_gray_nxt;
            r_full     <= (w_wr_gray_nxt == w_full_match);
            r_wr_ack   <= w_accept;
            r_overflow <= wr_en & r_full;
        end
    end

`ifdef FIFO_ALMOST_FULL_EN
    localparam logic [31:0] C_DEPTH  = 32'(1) << ADDR_RANGE;
    localparam logic [31:0] C_MARGIN = 32'(ALMOST_MARGIN);

    logic [C_PW-1:0] w_rd_bin;
    logic [C_PW-1:0] w_used;
    logic [31:0]     w_used_ext;
    logic            w_almost_nxt;
    logic            r_almost_full;

    // Gray to binary: each binary bit is the XOR of all Gray bits at or above it.
    always_comb begin
        w_rd_bin = '0;
        for (int i = 0; i < C_PW; i++) begin
            w_rd_bin[i] = ^(rd_ptr_sync >> i);
        end
    end

    // Occupancy after this cycle's write, modulo the pointer range.
    assign w_used       = w_wr_bin_nxt - w_rd_bin;
    assign w_used_ext   = {{(32 - C_PW){1'b0}}, w_used};
    // free = depth - used <= margin, rearranged to avoid an underflow.
    assign w_almost_nxt = ((w_used_ext + C_MARGIN) >= C_DEPTH) |
                          (w_wr_gray_nxt == w_full_match);

    // Registered almost_full, aligned with full.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_almost_full <= 1'b0;
        end else begin
            r_almost_full <= w_almost_nxt;
        end
    end

    assign almost_full = r_almost_full;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fifo_wr_ptr_full.sv
`default_nettype none
// ============================================================================
// Module      : tb_fifo_wr_ptr_full
// Description : Self-checking bench for fifo_wr_ptr_full (depth 8). A count-
//               based model (write/read positions, occupancy arithmetic)
//               predicts every output each cycle; directed scenarios add
//               literal expectations, then a randomized run follows.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fifo_wr_ptr_full;

    localparam int AR    = 3;
    localparam int DEPTH = 8;
    localparam int PMOD  = 16;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         wr_en;
    logic [AR:0]  rd_ptr_sync;
    logic [AR-1:0] wr_addr;
    logic [AR:0]  wr_ptr_gray;
    logic         wr_ram_en;
    logic         full;
    logic         wr_ack;
    logic         overflow;
`ifdef FIFO_ALMOST_FULL_EN
    logic         almost_full;
`endif

    fifo_wr_ptr_full #(.ADDR_RANGE(AR), .ALMOST_MARGIN(2)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .wr_en       (wr_en),
        .rd_ptr_sync (rd_ptr_sync),
        .wr_addr     (wr_addr),
        .wr_ptr_gray (wr_ptr_gray),
        .wr_ram_en   (wr_ram_en),
        .full        (full),
        .wr_ack      (wr_ack),
        .overflow    (overflow)
`ifdef FIFO_ALMOST_FULL_EN
        ,
        .almost_full (almost_full)
`endif
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Model state: positions modulo 16 plus registered flag expectations.
    int m_wr   = 0;
    int m_rd   = 0;
    int m_full = 0;
    int m_ack  = 0;
    int m_ovf  = 0;
    int m_af   = 0;
    logic [AR:0] prev_gray = '0;

    function automatic logic [AR:0] to_gray(input int b);
        logic [AR:0] v;
        v = 4'(b);
        return v ^ (v >> 1);
    endfunction

    function automatic int used_of(input int w, input int r);
        return (w - r + PMOD) % PMOD;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_wr = 0; m_rd = 0; m_full = 0; m_ack = 0; m_ovf = 0; m_af = 0;
        prev_gray = '0;
    endtask

    // One clock cycle, entered and left on a falling edge.
    task automatic cycle(input bit we, input bit rd_step);
        int acc;
        if (rd_step && used_of(m_wr, m_rd) > 0) m_rd = (m_rd + 1) % PMOD;
        wr_en       = we;
        rd_ptr_sync = to_gray(m_rd);
        #1;
        acc = (we && m_full == 0) ? 1 : 0;
        chk("wr_ram_en", int'(wr_ram_en), acc);
        if (acc == 1) chk("wr_addr", int'(wr_addr), m_wr % DEPTH);
        @(posedge clk);
        m_ovf  = (we && m_full == 1) ? 1 : 0;
        m_ack  = acc;
        m_wr   = (m_wr + acc) % PMOD;
        m_full = (used_of(m_wr, m_rd) == DEPTH) ? 1 : 0;
        m_af   = ((DEPTH - used_of(m_wr, m_rd)) <= 2 || m_full == 1) ? 1 : 0;
        #1;
        chk("wr_ptr_gray", int'(wr_ptr_gray), int'(to_gray(m_wr)));
        chk("full",        int'(full),        m_full);
        chk("wr_ack",      int'(wr_ack),      m_ack);
        chk("overflow",    int'(overflow),    m_ovf);
`ifdef FIFO_ALMOST_FULL_EN
        chk("almost_full", int'(almost_full), m_af);
`endif
        chk("gray_step_bits", $countones(prev_gray ^ wr_ptr_gray), acc);
        prev_gray = wr_ptr_gray;
        @(negedge clk);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_wr_addr"},  int'(wr_addr),     0);
        chk({tag, "_gray"},     int'(wr_ptr_gray), 0);
        chk({tag, "_full"},     int'(full),        0);
        chk({tag, "_ack"},      int'(wr_ack),      0);
        chk({tag, "_overflow"}, int'(overflow),    0);
`ifdef FIFO_ALMOST_FULL_EN
        chk({tag, "_almost"},   int'(almost_full), 0);
`endif
    endtask

    task automatic do_reset();
        @(negedge clk);
        wr_en = 1'b0;
        #2 rst_n = 1'b0;
        #1 check_all_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;
        rd_ptr_sync = '0;
        model_reset();
    endtask

    initial begin
        rst_n       = 1'b0;
        wr_en       = 1'b0;
        rd_ptr_sync = '0;
        #3 check_all_zero("por");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // 1: eight back-to-back writes fill the FIFO
        for (int i = 0; i < DEPTH; i++) cycle(1'b1, 1'b0);
        chk("t1_gray_literal", int'(wr_ptr_gray), 4'b1100);
        chk("t1_full_literal", int'(full), 1);

        // 2: writes while full overflow and leave the pointer alone
        for (int i = 0; i < 2; i++) begin
            cycle(1'b1, 1'b0);
            chk("t2_overflow_literal", int'(overflow), 1);
            chk("t2_gray_literal", int'(wr_ptr_gray), 4'b1100);
        end

        // 3: one read slot frees the FIFO, one write refills it at address 0
        cycle(1'b0, 1'b1);
        chk("t3_full_clear_literal", int'(full), 0);
        chk("t3_addr_literal", int'(wr_addr), 0);
        cycle(1'b1, 1'b0);
        chk("t3_full_again_literal", int'(full), 1);

        // 4: sixteen writes with the read pointer trailing by two
        do_reset();
        for (int i = 0; i < PMOD; i++) begin
            cycle(1'b1, used_of(m_wr, m_rd) >= 2);
            chk("t4_never_full", int'(full), 0);
        end
        chk("t4_gray_wrapped_literal", int'(wr_ptr_gray), 0);
        chk("t4_addr_wrapped_literal", int'(wr_addr), 0);

        // 5: reset asserted during the fifth write of a burst
        do_reset();
        for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0);
        wr_en = 1'b1;
        #2 rst_n = 1'b0;
        #1 check_all_zero("t5_midreset");
        @(negedge clk);
        chk("t5_held_ack", int'(wr_ack), 0);
        rst_n = 1'b1;
        model_reset();
        wr_en = 1'b1;
        #1 chk("t5_first_addr_literal", int'(wr_addr), 0);
        cycle(1'b1, 1'b0);

`ifdef FIFO_ALMOST_FULL_EN
        // 6: almost_full threshold with margin 2
        do_reset();
        for (int i = 0; i < 5; i++) cycle(1'b1, 1'b0);
        chk("t6_af_after5_literal", int'(almost_full), 0);
        cycle(1'b1, 1'b0);
        chk("t6_af_after6_literal", int'(almost_full), 1);
        cycle(1'b1, 1'b0);
        cycle(1'b1, 1'b0);
        chk("t6_full_literal", int'(full), 1);
        chk("t6_af_with_full_literal", int'(almost_full), 1);
`endif

        // Randomized traffic with a read side that lags and stalls.
        do_reset();
        for (int i = 0; i < 1500; i++) begin
            cycle(($urandom_range(0, 9) < 7), ($urandom_range(0, 9) < ((i / 300) % 2 == 0 ? 4 : 7)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
